// File: rtl/icache_fill_ctrl.sv
// Direct-mapped instruction cache with integrated line-refill FSM.
// Latency: hits return in the same cycle; a miss costs 4*(W+1) FILL + 1 WRITE cycles, then replays as a hit.
// Backpressure: fetch is held with if_stall while a miss is serviced; memory paces the fill with mem_rdy.
//
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   if_req, if_addr          fetch request and word address (held by fetch while stalled)
//   flush                    one-cycle pulse, invalidates every line
//   if_instr, if_valid       hit data (zero when not a hit) and hit strobe
//   if_stall                 fetch must hold its PC
//   mem_re, mem_addr         word read request towards memory
//   mem_rdata, mem_rdy       read data, captured on the cycle mem_rdy is high
module icache_fill_ctrl #(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 16,
  parameter int NUM_LINES      = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              flush,
  output logic [DATA_W-1:0] if_instr,
  output logic              if_valid,
  output logic              if_stall,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rdy
);

  localparam int OFF_W  = $clog2(WORDS_PER_LINE);
  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int BASE_W = ADDR_W - OFF_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Storage arrays: only the valid bits are reset.
  logic [NUM_LINES-1:0] r_valid;
  logic [TAG_W-1:0]     r_tag  [NUM_LINES];
  logic [DATA_W-1:0]    r_data [NUM_LINES][WORDS_PER_LINE];

  // Refill context: line base address, word counter, staging buffer.
  logic [BASE_W-1:0] r_base;
  logic [OFF_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_buf [WORDS_PER_LINE];
  logic              r_flush_pend;

  logic [IDX_W-1:0] w_idx;
  logic [OFF_W-1:0] w_off;
  logic [TAG_W-1:0] w_tag;
  logic             w_hit;
  logic             w_miss;
  logic             w_last;
  logic [IDX_W-1:0] w_fill_idx;
  logic [TAG_W-1:0] w_fill_tag;

  assign w_idx      = if_addr[OFF_W +: IDX_W];
  assign w_off      = if_addr[OFF_W-1:0];
  assign w_tag      = if_addr[ADDR_W-1 -: TAG_W];
  assign w_hit      = (r_state == S_IDLE) && if_req && r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_miss     = (r_state == S_IDLE) && if_req && !w_hit;
  assign w_last     = (r_cnt == OFF_W'(WORDS_PER_LINE - 1));
  assign w_fill_idx = r_base[IDX_W-1:0];
  assign w_fill_tag = r_base[BASE_W-1 -: TAG_W];

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_miss) w_state_nxt = S_FILL;
      S_FILL:  if (mem_rdy && w_last) w_state_nxt = S_WRITE;
      S_WRITE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    if_instr = '0;
    if_valid = 1'b0;
    if_stall = 1'b0;
    mem_re   = 1'b0;
    mem_addr = '0;
    case (r_state)
      S_IDLE: begin
        if (w_hit) begin
          if_valid = 1'b1;
          if_instr = r_data[w_idx][w_off];
        end else if (if_req) begin
          if_stall = 1'b1;
        end
      end
      S_FILL: begin
        if_stall = 1'b1;
        mem_re   = 1'b1;
        mem_addr = {r_base, r_cnt};
      end
      S_WRITE: begin
        if_stall = 1'b1;
      end
      default: ;
    endcase
  end

  // Control state: valid bits, fill counter, deferred flush.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid      <= '0;
      r_cnt        <= '0;
      r_flush_pend <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // Lookup this cycle already used the old valid bits.
          if (flush) r_valid <= '0;
          if (w_miss) r_cnt <= '0;
        end
        S_FILL: begin
          if (flush) r_flush_pend <= 1'b1;
          if (mem_rdy) r_cnt <= r_cnt + 1'b1;
        end
        S_WRITE: begin
          // A flush seen at any point during the refill overrides the install.
          if (flush || r_flush_pend) begin
            r_valid <= '0;
          end else begin
            r_valid[w_fill_idx] <= 1'b1;
          end
          r_flush_pend <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Datapath: base capture, word staging and line install (no reset needed,
  // but gated so a reset edge never installs a partial line).
  always_ff @(posedge clk) begin
    if (rst) begin
      if (w_miss) begin
        r_base <= if_addr[ADDR_W-1:OFF_W];
      end
      if ((r_state == S_FILL) && mem_rdy) begin
        r_buf[r_cnt] <= mem_rdata;
      end
      if (r_state == S_WRITE) begin
        r_tag[w_fill_idx] <= w_fill_tag;
        for (int w = 0; w < WORDS_PER_LINE; w++) begin
          r_data[w_fill_idx][w] <= r_buf[w];
        end
      end
    end
  end

endmodule
